ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage. Consumes the operands and function code

---
 rtl/ex_muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-step multiply/divide unit for the EX stage; writes HI/LO and
// holds the front of the pipeline while an operation is in flight.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MD_Start,
  input  logic [1:0]       MD_Op,
  input  logic [WIDTH-1:0] MD_DatoA,
  input  logic [WIDTH-1:0] MD_DatoB,
  input  logic             MD_WrHI,
  input  logic             MD_WrLO,
  output logic             MD_Stall,
  output logic             MD_Done,
  output logic [WIDTH-1:0] MD_HI,
  output logic [WIDTH-1:0] MD_LO
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH:0]     mult_sum_s;
  logic [WIDTH:0]     div_shift_s, div_trial_s;
  logic [2*WIDTH-1:0] mult_next_s, div_next_s, step_s, prod_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  // Operand magnitudes and result signs captured at Start
  always_comb begin
    sign_a_s = ~MD_Op[0] & MD_DatoA[WIDTH-1];
    sign_b_s = ~MD_Op[0] & MD_DatoB[WIDTH-1];
    if (sign_a_s) begin
      abs_a_s = '0 - MD_DatoA;
    end else begin
      abs_a_s = MD_DatoA;
    end
    if (sign_b_s) begin
      abs_b_s = '0 - MD_DatoB;
    end else begin
      abs_b_s = MD_DatoB;
    end
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) iteration.
  // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    if (acc_q[0]) begin
      mult_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    end else begin
      mult_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mult_next_s = {mult_sum_s, acc_q[WIDTH-1:1]};
    div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial_s = div_shift_s - {1'b0, opb_q};
    if (!div_trial_s[WIDTH]) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    if (is_div_q) begin
      step_s = div_next_s;
    end else begin
      step_s = mult_next_s;
    end
  end

  // Sign correction of the final iteration; divide-by-zero overrides the datapath
  always_comb begin
    if (neg_res_q) begin
      prod_s = '0 - step_s;
    end else begin
      prod_s = step_s;
    end
    if (!is_div_q) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (dbz_q) begin
      res_hi_s = araw_q;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_lo_s = prod_s[WIDTH-1:0];
      if (neg_rem_q) begin
        res_hi_s = '0 - step_s[2*WIDTH-1:WIDTH];
      end else begin
        res_hi_s = step_s[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Control FSM: Start is accepted in IDLE and DONE, HI/LO writes only when not BUSY
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    araw_d    = araw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (MD_Start) begin
          state_d   = S_BUSY;
          count_d   = LAST_STEP;
          is_div_d  = MD_Op[1];
          neg_res_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          dbz_d     = MD_Op[1] & (MD_DatoB == '0);
          araw_d    = MD_DatoA;
          if (MD_Op[1]) begin
            acc_d = {{WIDTH{1'b0}}, abs_a_s};
            opb_d = abs_b_s;
          end else begin
            acc_d = {{WIDTH{1'b0}}, abs_b_s};
            opb_d = abs_a_s;
          end
        end else begin
          state_d = S_IDLE;
          if (MD_WrHI) begin
            hi_d = MD_DatoA;
          end else begin
            hi_d = hi_q;
          end
          if (MD_WrLO) begin
            lo_d = MD_DatoA;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_BUSY: begin
        acc_d = step_s;
        if (count_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      araw_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      araw_q    <= araw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign MD_Stall = (state_q == S_BUSY) |
                    (((state_q == S_IDLE) | (state_q == S_DONE)) & MD_Start);
  assign MD_Done  = done_q;
  assign MD_HI    = hi_q;
  assign MD_LO    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO pushed at Start from an
// arithmetic reference model, popped and compared by a monitor on every Done.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start, md_wrhi, md_wrlo;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        stall, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] model_hi, model_lo;

  ex_muldiv_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clk(clk), .rst(rst), .MD_Start(md_start), .MD_Op(md_op),
    .MD_DatoA(md_a), .MD_DatoB(md_b), .MD_WrHI(md_wrhi), .MD_WrLO(md_wrlo),
    .MD_Stall(stall), .MD_Done(done), .MD_HI(hi), .MD_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_hi", hi, mon_e[63:32]);
        check("sb_lo", lo, mon_e[31:0]);
        model_hi = mon_e[63:32];
        model_lo = mon_e[31:0];
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1;
    md_op = op;
    md_a = a;
    md_b = b;
    exp_q.push_back(ref_result(op, a, b));
    @(negedge clk);
    md_start = 1'b0;
    md_a = $urandom;
    md_b = $urandom;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      @(negedge clk);
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: got done=0 expected done=1 within 40 cycles", name);
    end
  endtask

  task automatic run_const(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_done(name);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick(input bit zero_bias);
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return zero_bias ? 32'd0 : 32'(  $urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int edges, stall_cnt, nd;
    bit got;
    rst = 1'b1;
    md_start = 1'b0;
    md_wrhi = 1'b0;
    md_wrlo = 1'b0;
    md_op = 2'b00;
    md_a = 32'd0;
    md_b = 32'd0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Latency and stall window on MULTU max*max
    @(negedge clk);
    md_start = 1'b1;
    md_op = 2'b01;
    md_a = 32'hFFFFFFFF;
    md_b = 32'hFFFFFFFF;
    exp_q.push_back(ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF));
    #1;
    edges = 0;
    stall_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (stall) stall_cnt++;
      @(posedge clk);
      #1;
      md_start = 1'b0;
      edges++;
      if (done) got = 1'b1;
      #1;
    end
    check("lat_done_seen", {31'd0, got}, 32'd1);
    check("lat_edges", 32'(edges), 32'd33);
    check("lat_stall_cycles", 32'(stall_cnt), 32'd33);
    check("lat_stall_in_done", {31'd0, stall}, 32'd0);
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);

    run_const("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_const("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_const("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_const("divu_zero", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
    run_const("div_wrap", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Back-to-back: Start in the DONE cycle
    issue(2'b01, 32'd1000, 32'd3000);
    wait_done("b2b_first");
    md_start = 1'b1;
    md_op = 2'b11;
    md_a = 32'd1000;
    md_b = 32'd7;
    exp_q.push_back(ref_result(2'b11, 32'd1000, 32'd7));
    #1;
    check("b2b_stall_done", {31'd0, stall}, 32'd1);
    @(negedge clk);
    md_start = 1'b0;
    check("b2b_stall_busy", {31'd0, stall}, 32'd1);
    wait_done("b2b_second");

    // MTHI while BUSY is dropped
    issue(2'b00, 32'd12345, 32'hFFFFFF00);
    repeat (3) @(negedge clk);
    md_wrhi = 1'b1;
    md_a = 32'h00001234;
    @(negedge clk);
    md_wrhi = 1'b0;
    check("mthi_busy", hi, model_hi);
    wait_done("mthi_busy");

    // MTLO in IDLE, then MTHI+MTLO together
    @(negedge clk);
    md_wrlo = 1'b1;
    md_a = 32'h0000ABCD;
    @(negedge clk);
    md_wrlo = 1'b0;
    check("mtlo_idle_lo", lo, 32'h0000ABCD);
    check("mtlo_idle_hi", hi, model_hi);
    model_lo = 32'h0000ABCD;
    md_wrhi = 1'b1;
    md_wrlo = 1'b1;
    md_a = 32'h5555AAAA;
    @(negedge clk);
    md_wrhi = 1'b0;
    md_wrlo = 1'b0;
    check("mthilo_hi", hi, 32'h5555AAAA);
    check("mthilo_lo", lo, 32'h5555AAAA);
    model_hi = 32'h5555AAAA;
    model_lo = 32'h5555AAAA;

    // Start and MTHI in the same cycle: Start wins
    @(negedge clk);
    md_start = 1'b1;
    md_wrhi = 1'b1;
    md_op = 2'b10;
    md_a = 32'd77;
    md_b = 32'hFFFFFFF6;
    exp_q.push_back(ref_result(2'b10, 32'd77, 32'hFFFFFFF6));
    @(negedge clk);
    md_start = 1'b0;
    md_wrhi = 1'b0;
    check("start_beats_wr", hi, 32'h5555AAAA);
    wait_done("start_beats_wr");

    // Reset mid-operation aborts with no Done
    @(negedge clk);
    md_start = 1'b1;
    md_op = 2'b01;
    md_a = 32'd3;
    md_b = 32'd5;
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);

    // Randomized operations, with Start ignored while BUSY
    repeat (30) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      issue(op, pick(1'b0), pick(op[1]));
      if ($urandom_range(0, 3) == 0) begin
        md_start = 1'b1;
        md_op = 2'($urandom_range(0, 3));
        @(negedge clk);
        md_start = 1'b0;
      end
      wait_done("rand");
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
